// File: rtl/rr_mux.sv
// N-channel, W-bit registered mux with valid/ready handshake and round-robin grant.
// Define RR_MUX_FIXED_PRIO_EN for lowest-index-wins fixed priority (no rotating pointer).
module rr_mux #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CW       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  input  logic                      out_ready
);

  logic                ld;
  logic                found;
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       gidx;
  logic [WIDTH-1:0]    gdata;
  logic [CW-1:0]       ptr;
  logic                xfer;
  int                  idx;

  assign ld = ~out_valid | out_ready;

  // Scan ptr, ptr+1, ... with explicit wrap so non-power-of-two counts work.
  always_comb begin
    found = 1'b0;
    grant = '0;
    gidx  = '0;
    gdata = '0;
    idx   = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = CW'(idx);
        gdata      = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Held low during reset so no producer sees a phantom accept.
  assign in_ready = (ld && rst_n) ? grant : '0;
  assign xfer     = ld & found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_chan  <= gidx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (xfer)
      ptr <= (gidx == CW'(CHANNELS-1)) ? '0 : gidx + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Randomized + directed bench for rr_mux: a 4-channel and a 3-channel instance
// run side by side against a queue-free behavioural arbiter model.
module tb_rr_mux;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  iv4, ir4;
  logic [31:0] id4;
  logic        ov4, or4;
  logic [7:0]  od4;
  logic [1:0]  oc4;

  logic [2:0]  iv3, ir3;
  logic [23:0] id3;
  logic        ov3, or3;
  logic [7:0]  od3;
  logic [1:0]  oc3;

  rr_mux #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_chan(oc4), .out_ready(or4));

  rr_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_chan(oc3), .out_ready(or3));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model state, index 0 = 4-channel instance, 1 = 3-channel instance
  int         m_ptr [2];
  logic       m_ov  [2];
  logic [7:0] m_od  [2];
  int         m_oc  [2];

  function automatic int pick(input int n, input int p, input logic [3:0] v);
    int start;
`ifdef RR_MUX_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < n; k++)
      if (v[(start + k) % n]) return (start + k) % n;
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_ov[u] = 1'b0; m_od[u] = 8'h00; m_oc[u] = 0;
    end
  endtask

  task automatic model_step(input int u, input int n, input logic [3:0] v,
                            input logic [31:0] d, input logic rdy, output logic [3:0] er);
    logic ld;
    int   g;
    ld = !m_ov[u] || rdy;
    g  = pick(n, m_ptr[u], v);
    er = 4'b0;
    if (ld && g >= 0) begin
      er[g]    = 1'b1;
      m_od[u]  = d[g*8 +: 8];
      m_oc[u]  = g;
      m_ov[u]  = 1'b1;
      m_ptr[u] = (g + 1) % n;
    end else if (m_ov[u] && rdy) begin
      m_ov[u] = 1'b0;
    end
  endtask

  task automatic chk_out();
    chk("ov4", ov4, m_ov[0]);
    chk("od4", od4, m_od[0]);
    chk("oc4", oc4, m_oc[0]);
    chk("ov3", ov3, m_ov[1]);
    chk("od3", od3, m_od[1]);
    chk("oc3", oc3, m_oc[1]);
  endtask

  // Entered at a negedge: check registered outputs, drive, check in_ready, advance.
  task automatic cycle(input logic [3:0] v4, input logic [31:0] d4, input logic r4,
                       input logic [2:0] v3, input logic [23:0] d3, input logic r3);
    logic [3:0] e4, e3;
    chk_out();
    iv4 = v4; id4 = d4; or4 = r4;
    iv3 = v3; id3 = d3; or3 = r3;
    #1;
    model_step(0, 4, v4, d4, r4, e4);
    model_step(1, 3, {1'b0, v3}, {8'h00, d3}, r3, e3);
    chk("ir4", ir4, e4);
    chk("ir3", ir3, {1'b0, e3[2:0]});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    iv4 = 4'hF; id4 = 32'h13121110; or4 = 1'b1;
    iv3 = 3'h7; id3 = 24'h222120;   or3 = 1'b1;
    model_reset();
    #2;
    chk("rst_ir4", ir4, 0);
    chk("rst_ir3", ir3, 0);
    chk_out();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // idle
    repeat (5) cycle(4'h0, 32'h0, 1'b1, 3'h0, 24'h0, 1'b1);
    // single channel 2, then wrap on the 3-channel instance
    cycle(4'b0100, 32'h00A50000, 1'b1, 3'b100, 24'h5A0000, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1, 3'b001, 24'h00003C, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1, 3'b000, 24'h0, 1'b1);
    // fairness: all valid, no backpressure
    repeat (8) cycle(4'hF, 32'h13121110, 1'b1, 3'h7, 24'h222120, 1'b1);
    // backpressure with channels 0 and 2 valid
    cycle(4'b0010, 32'h13121110, 1'b1, 3'b010, 24'h222120, 1'b1);
    repeat (3) cycle(4'b0101, 32'h13121110, 1'b0, 3'b101, 24'h222120, 1'b0);
    repeat (2) cycle(4'b0101, 32'h13121110, 1'b1, 3'b101, 24'h222120, 1'b1);
    cycle(4'h0, 32'h0, 1'b1, 3'h0, 24'h0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(4'($urandom), $urandom, 1'($urandom_range(0, 3) != 0),
            3'($urandom), 24'($urandom), 1'($urandom_range(0, 3) != 0));

    // async reset while a word is held
    cycle(4'hF, 32'hDEADBEEF, 1'b0, 3'h7, 24'hABCDEF, 1'b0);
    chk_out();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ov4", ov4, 0);
    chk("arst_ov3", ov3, 0);
    chk("arst_ir4", ir4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0011, 32'h00002211, 1'b1, 3'b011, 24'h004433, 1'b1);
    repeat (3) cycle(4'($urandom), $urandom, 1'b1, 3'($urandom), 24'($urandom), 1'b1);
    chk_out();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
